// File: rtl/pipe_stage_chain.sv
// Parametrised valid/ready pipeline register chain with per-stage flush and bubble collapsing.
// Defining PIPE_STAGE_PERF_CNT_EN builds the saturating stall/flush performance counters.
module pipe_stage_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 5,
   parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic [DEPTH-1:0]           flush_mask,
   output logic [DEPTH-1:0]           stage_valid,
   output logic [DEPTH*WIDTH-1:0]     stage_data,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic [31:0]                stall_cnt,
   output logic [31:0]                flush_cnt
);
   localparam int OCC_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q, valid_d, ev, rdy;
   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   assign ev = valid_q & ~flush_mask;

   // A stage can load when it is empty after flush or its contents will move on.
   always_comb begin
      logic r;
      r   = out_ready;
      rdy = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         r      = ~ev[i] | r;
         rdy[i] = r;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (rdy[0]) begin
         valid_d[0] = in_valid;
         if (in_valid) data_d[0] = in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
         if (rdy[i]) begin
            valid_d[i] = ev[i-1];
            if (ev[i-1]) data_d[i] = data_q[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < DEPTH; i++) data_q[i] <= RESET_DATA;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign in_ready    = rdy[0] & ~reset;
   assign out_valid   = ev[DEPTH-1];
   assign out_data    = data_q[DEPTH-1];
   assign stage_valid = valid_q;

   always_comb begin
      occupancy  = '0;
      stage_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         occupancy                     = occupancy + OCC_W'(valid_q[i]);
         stage_data[i*WIDTH +: WIDTH] = data_q[i];
      end
   end

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0]      stall_cnt_q, flush_cnt_q;
   logic [OCC_W-1:0] killed;
   logic [32:0]      flush_sum;

   // The extra sum bit detects overflow so the flush counter can saturate.
   always_comb begin
      killed = '0;
      for (int i = 0; i < DEPTH; i++) killed = killed + OCC_W'(valid_q[i] & flush_mask[i]);
      flush_sum = {1'b0, flush_cnt_q} + 33'(killed);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (in_valid && !in_ready && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
         flush_cnt_q <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
